intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 32, data/address width.
REQ-002 SHALL have parameter PEND_BASE, default 32'hF0000100, pending-register address.
REQ-003 SHALL have parameter MASK_BASE, default 32'hF0000104, mask-register address.
REQ-004 SHALL have parameter VEC_BASE, default 32'hF0000108, vector/EOI register address.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port we  input  1  bus write strobe.
REQ-008 SHALL have port re  input  1  bus read strobe.
REQ-009 SHALL have port memAddr  input  BITS  bus address.
REQ-010 SHALL have port dataBusIn  input  BITS  bus write data.
REQ-011 SHALL have port dataBusOut  output  BITS  bus read data.
REQ-012 SHALL have port irqSrc  input  4  level requests from devices (bit0 timer, bit1 keys, bit2 switches, bit3 spare).
REQ-013 SHALL have port intAck  input  1  CPU accepts the presented interrupt.
REQ-014 SHALL have port irq  output  1  interrupt request to CPU.
REQ-015 SHALL have port irqId  output  2  index of the presented source.

Function
REQ-016 SHALL register irqSrc each cycle and set pend[i] on a 0->1 edge of irqSrc[i].
REQ-017 SHALL clear pend[i] on a bus write (we=1) to PEND_BASE with dataBusIn[i]=1 (write-1-to-clear); a new edge in the same cycle SHALL win (bit stays 1).
REQ-018 SHALL load mask[3:0] from dataBusIn[3:0] on a bus write to MASK_BASE; mask[i]=1 enables source i.
REQ-019 SHALL implement states IDLE, ASSERT, SERVICE.
REQ-020 IDLE: if (pend & mask) != 0, SHALL latch the winner into irqId and move to ASSERT; otherwise stay.
REQ-021 ASSERT: irq=1; irqId stable; on intAck=1 SHALL clear pend[irqId] (edge-set still wins) and move to SERVICE.
REQ-022 ASSERT: if mask[irqId] is cleared before intAck, SHALL drop irq and return to IDLE without clearing pend.
REQ-023 SERVICE: irq=0; a bus write to VEC_BASE (any data) is EOI and SHALL return to IDLE.
REQ-024 intAck outside ASSERT and EOI outside SERVICE SHALL be ignored.
REQ-025 Latency: pend set at edge k in IDLE -> ASSERT and irq=1 after edge k+1.
REQ-026 Reads combinational: PEND_BASE -> {0, pend}; MASK_BASE -> {0, mask}; VEC_BASE -> {0, state[1:0] at bits 9:8, irqId at bits 1:0}; any other address or re=0 -> 0.
REQ-027 A bus write SHALL never drive dataBusOut (we=1 forces 0).

Reset
REQ-028 On reset SHALL set state=IDLE, pend=0, mask=0, irqSrc history=0, irq=0, irqId=0, rotation pointer=0; dataBusOut SHALL be 0 the cycle after reset while re=0.
REQ-029 Reset during ASSERT or SERVICE SHALL abandon the interrupt; no pend bit survives.

Configuration
REQ-030 With INTR_CTRL_ROTATE_EN defined, winner SHALL be the first enabled pending index at or after the rotation pointer (wrapping 3->0), and the pointer SHALL become irqId+1 (mod 4) on intAck.
REQ-031 Without INTR_CTRL_ROTATE_EN, winner SHALL be the lowest enabled pending index; no pointer exists.

Verification
REQ-032 mask=4'b0001, irqSrc[0] 0->1 -> pend=0001 next edge, irq=1 one edge later, irqId=0; intAck -> irq=0, pend=0000, VEC read bits 9:8 = SERVICE; EOI write -> IDLE.
REQ-033 mask=0, irqSrc[1] pulses -> pend=0010, irq stays 0; then mask=4'b0010 -> irq=1, irqId=1.
REQ-034 Sources 0 and 2 edge same cycle, mask=4'b1111 -> irqId=0 first; after ack+EOI, irqId=2.
REQ-035 ROTATE_EN, source 0 held pending, serviced once, re-edged together with source 2 -> irqId=2 next (pointer=1); without macro -> irqId=0.
REQ-036 Write PEND_BASE 4'b0001 same cycle as new irqSrc[0] edge -> pend[0] remains 1; reset asserted in SERVICE -> irq=0, pend=0, mask=0, state IDLE.

Source files
------------

// File: rtl/intr_ctrl.sv
// Purpose : four-source interrupt controller with edge-latched pending bits,
//           per-source mask and an IDLE/ASSERT/SERVICE handshake with the CPU.
// Latency : pend sets on the edge after a source rises; irq follows one edge later.
// Backpressure: none; bus reads/writes complete in one cycle, reads are combinational.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   we, re          bus write / read strobes
//   memAddr         bus address (PEND_BASE, MASK_BASE, VEC_BASE decoded)
//   dataBusIn/Out   bus write data / combinational read data (0 while we=1)
//   irqSrc[3:0]     level requests (timer, keys, switches, spare)
//   intAck          CPU accepts the presented interrupt
//   irq, irqId      request to CPU and index of the presented source
//
// Build option: define INTR_CTRL_ROTATE_EN for round-robin arbitration.
// Without it the lowest enabled pending index wins.

module intr_ctrl #(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] PEND_BASE = BITS'(32'hF0000100),
  parameter logic [BITS-1:0] MASK_BASE = BITS'(32'hF0000104),
  parameter logic [BITS-1:0] VEC_BASE  = BITS'(32'hF0000108)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  input  logic [3:0]      irqSrc,
  input  logic            intAck,
  output logic            irq,
  output logic [1:0]      irqId
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] pend, pend_n;
  logic [3:0] mask;
  logic [3:0] src_q;
  logic [1:0] irq_id, irq_id_n;
  logic [3:0] req;
  logic [3:0] edge_set;
  logic [1:0] win_id;
  logic       win_vld;
  logic       wr_pend, wr_mask, wr_vec;

  assign wr_pend  = we && (memAddr == PEND_BASE);
  assign wr_mask  = we && (memAddr == MASK_BASE);
  assign wr_vec   = we && (memAddr == VEC_BASE);
  assign edge_set = irqSrc & ~src_q;
  assign req      = pend & mask;

`ifdef INTR_CTRL_ROTATE_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  // Scan from the highest offset down so the request closest to ptr is the
  // last assignment and therefore the winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (state == ASSERT && intAck) begin
      ptr <= irq_id + 2'd1;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        win_vld = 1'b1;
        win_id  = 2'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pend   <= 4'd0;
      irq_id <= 2'd0;
      src_q  <= 4'd0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      irq_id <= irq_id_n;
      src_q  <= irqSrc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= 4'd0;
    end else if (wr_mask) begin
      mask <= dataBusIn[3:0];
    end
  end

  always_comb begin
    state_n  = state;
    irq_id_n = irq_id;
    pend_n   = pend;
    if (wr_pend) begin
      pend_n = pend_n & ~dataBusIn[3:0];
    end
    case (state)
      IDLE: begin
        if (win_vld) begin
          irq_id_n = win_id;
          state_n  = ASSERT;
        end
      end
      ASSERT: begin
        if (intAck) begin
          pend_n[irq_id] = 1'b0;
          state_n        = SERVICE;
        end else if (!mask[irq_id]) begin
          // Source masked while presented: withdraw, leave it pending.
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (wr_vec) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A fresh rising edge always beats any clear in the same cycle.
    pend_n = pend_n | edge_set;
  end

  assign irq   = (state == ASSERT);
  assign irqId = irq_id;

  always_comb begin
    dataBusOut = '0;
    if (re && !we) begin
      if (memAddr == PEND_BASE) begin
        dataBusOut[3:0] = pend;
      end else if (memAddr == MASK_BASE) begin
        dataBusOut[3:0] = mask;
      end else if (memAddr == VEC_BASE) begin
        dataBusOut[9:8] = state;
        dataBusOut[1:0] = irq_id;
      end
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Purpose : directed self-checking bench for intr_ctrl.
// Latency : inputs driven and outputs sampled 1 ns after the rising edge.
// Backpressure: n/a.

module tb_intr_ctrl;

  localparam logic [31:0] PEND = 32'hF0000100;
  localparam logic [31:0] MASK = 32'hF0000104;
  localparam logic [31:0] VEC  = 32'hF0000108;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [31:0] memAddr, dataBusIn, dataBusOut;
  logic [3:0]  irqSrc;
  logic        intAck;
  logic        irq;
  logic [1:0]  irqId;

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  intr_ctrl dut (
    .clk(clk), .reset(reset), .we(we), .re(re),
    .memAddr(memAddr), .dataBusIn(dataBusIn), .dataBusOut(dataBusOut),
    .irqSrc(irqSrc), .intAck(intAck), .irq(irq), .irqId(irqId)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    memAddr = a;
    re = 1'b1;
    #1;
    v = dataBusOut;
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    memAddr = a;
    dataBusIn = v;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (irqId !== 2'd0) begin errors++; $display("FAIL reset_irqId got=%0d exp=0", irqId); end
    checks++; if (dataBusOut !== 32'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dataBusOut); end
    rd(PEND, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pend got=%h exp=0", d); end
    rd(MASK, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_mask got=%h exp=0", d); end
    rd(VEC, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_vec got=%h exp=0", d); end
  endtask

  task automatic test_basic();
    wr(MASK, 32'h1);
    irqSrc = 4'b0001;
    tick();
    rd(PEND, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_pend got=%h exp=1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got=%b exp=1", irq); end
    checks++; if (irqId !== 2'd0) begin errors++; $display("FAIL basic_id got=%0d exp=0", irqId); end
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_ack got=%b exp=0", irq); end
    rd(PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_ack got=%h exp=0", d); end
    rd(VEC, d);
    checks++; if (d[9:8] !== 2'd2) begin errors++; $display("FAIL basic_service got=%0d exp=2", d[9:8]); end
    wr(VEC, 32'h0);
    rd(VEC, d);
    checks++; if (d[9:8] !== 2'd0) begin errors++; $display("FAIL basic_eoi got=%0d exp=0", d[9:8]); end
    irqSrc = 4'b0000;
    tick();
  endtask

  task automatic test_masked();
    wr(MASK, 32'h0);
    irqSrc = 4'b0010;
    tick();
    irqSrc = 4'b0000;
    tick();
    rd(PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL masked_pend got=%h exp=2", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", irq); end
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    rd(PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL idle_ack_ignored got=%h exp=2", d); end
    wr(MASK, 32'h2);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got=%b exp=1", irq); end
    checks++; if (irqId !== 2'd1) begin errors++; $display("FAIL unmask_id got=%0d exp=1", irqId); end
    wr(MASK, 32'h0);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL remask_irq got=%b exp=0", irq); end
    rd(PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL remask_pend got=%h exp=2", d); end
    wr(PEND, 32'h2);
    rd(PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_pend got=%h exp=0", d); end
  endtask

  task automatic test_priority();
    wr(MASK, 32'hF);
    irqSrc = 4'b0101;
    tick();
    irqSrc = 4'b0000;
    tick();
    checks++; if (irqId !== 2'd0) begin errors++; $display("FAIL prio_first got=%0d exp=0", irqId); end
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    rd(PEND, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL prio_pend got=%h exp=4", d); end
    wr(VEC, 32'h0);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_second_irq got=%b exp=1", irq); end
    checks++; if (irqId !== 2'd2) begin errors++; $display("FAIL prio_second got=%0d exp=2", irqId); end
    wr(VEC, 32'h0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL eoi_in_assert got=%b exp=1", irq); end
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    wr(VEC, 32'h0);
    rd(VEC, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL prio_vec_idle got=%h exp=2", d); end
  endtask

  task automatic test_rotate();
    logic [1:0] exp_a, exp_b;
`ifdef INTR_CTRL_ROTATE_EN
    exp_a = 2'd2; exp_b = 2'd0;
`else
    exp_a = 2'd0; exp_b = 2'd2;
`endif
    do_reset();
    wr(MASK, 32'hF);
    irqSrc = 4'b0001;
    tick();
    tick();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    wr(VEC, 32'h0);
    irqSrc = 4'b0000;
    tick();
    irqSrc = 4'b0101;
    tick();
    irqSrc = 4'b0000;
    tick();
    checks++; if (irqId !== exp_a) begin errors++; $display("FAIL rotate_first got=%0d exp=%0d", irqId, exp_a); end
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    wr(VEC, 32'h0);
    tick();
    checks++; if (irqId !== exp_b) begin errors++; $display("FAIL rotate_second got=%0d exp=%0d", irqId, exp_b); end
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    wr(VEC, 32'h0);
    rd(PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rotate_pend got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    memAddr = PEND; dataBusIn = 32'h1; we = 1'b1; irqSrc = 4'b0001;
    tick();
    we = 1'b0;
    rd(PEND, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_beats_w1c got=%h exp=1", d); end
    wr(PEND, 32'h1);
    rd(PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_held got=%h exp=0", d); end
    memAddr = MASK; dataBusIn = 32'h0; we = 1'b1; re = 1'b1;
    #1;
    checks++; if (dataBusOut !== 32'h0) begin errors++; $display("FAIL write_read_dout got=%h exp=0", dataBusOut); end
    we = 1'b0; re = 1'b0;
    irqSrc = 4'b0000;
    wr(MASK, 32'h1);
    irqSrc = 4'b0001;
    tick();
    tick();
    intAck = 1'b1; irqSrc = 4'b1001;
    tick();
    intAck = 1'b0;
    rd(PEND, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL svc_pend got=%h exp=8", d); end
    rd(VEC, d);
    checks++; if (d[9:8] !== 2'd2) begin errors++; $display("FAIL svc_state got=%0d exp=2", d[9:8]); end
    irqSrc = 4'b0000;
    do_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL svc_reset_irq got=%b exp=0", irq); end
    rd(PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL svc_reset_pend got=%h exp=0", d); end
    rd(MASK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL svc_reset_mask got=%h exp=0", d); end
    rd(VEC, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL svc_reset_vec got=%h exp=0", d); end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    irqSrc = 4'b0000; intAck = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_masked();
    test_priority();
    test_rotate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
